// File: rtl/crypto_key_vault_if.sv
// rtl/crypto_key_vault_if.sv - provisioning/key-fetch bus of the multi-slot key vault
interface crypto_key_vault_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_SLOTS = 4,
  parameter int KEY_WORDS = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int WORD_W    = $clog2(KEY_WORDS)
);
  logic [SLOT_W-1:0]    slot_sel;
  logic                 write_en;
  logic [DATA_W-1:0]    data_in;
  logic                 lock_req;
  logic                 zeroize_req;
  logic                 rd_req;
  logic [WORD_W-1:0]    rd_word;
  logic                 debug_mode;
  logic [DATA_W-1:0]    data_out;
  logic                 rd_valid;
  logic                 busy;
  logic                 err;
  logic [NUM_SLOTS-1:0] slot_full;
  logic [NUM_SLOTS-1:0] slot_locked;

  modport master (
    output slot_sel, write_en, data_in, lock_req, zeroize_req, rd_req, rd_word, debug_mode,
    input  data_out, rd_valid, busy, err, slot_full, slot_locked
  );

  modport slave (
    input  slot_sel, write_en, data_in, lock_req, zeroize_req, rd_req, rd_word, debug_mode,
    output data_out, rd_valid, busy, err, slot_full, slot_locked
  );
endinterface

// File: rtl/crypto_key_vault.sv
// rtl/crypto_key_vault.sv - multi-slot key store with write-once lock, timed zeroize and masked reads
module crypto_key_vault #(
  parameter int DATA_W    = 16,
  parameter int NUM_SLOTS = 4,
  parameter int KEY_WORDS = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int WORD_W    = $clog2(KEY_WORDS)
) (
  input logic               clk,
  input logic               resetn,
  crypto_key_vault_if.slave bus
);

  typedef enum logic {IDLE, ZERO} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    mem_q [NUM_SLOTS][KEY_WORDS];
  logic [WORD_W-1:0]    ptr_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] full_q, locked_q;
  logic [SLOT_W-1:0]    zslot_q;
  logic [WORD_W-1:0]    zcnt_q;
  logic [DATA_W-1:0]    data_out_q;
  logic                 rd_valid_q, err_q;

  logic err_d, wr_fire, lock_fire, rd_fire, rd_ok, zero_start, zero_done, slot_ok, any_req;

  assign slot_ok = int'(bus.slot_sel) < NUM_SLOTS;
  assign any_req = bus.zeroize_req | bus.write_en | bus.lock_req | bus.rd_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // One command per cycle in IDLE, highest priority wins; the rest are dropped without err.
  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    wr_fire    = 1'b0;
    lock_fire  = 1'b0;
    rd_fire    = 1'b0;
    rd_ok      = 1'b0;
    zero_start = 1'b0;
    zero_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.zeroize_req) begin
          if (slot_ok) begin
            state_d    = ZERO;
            zero_start = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.write_en) begin
          if (slot_ok && !full_q[bus.slot_sel] && !locked_q[bus.slot_sel]) wr_fire = 1'b1;
          else                                                             err_d   = 1'b1;
        end else if (bus.lock_req) begin
          if (slot_ok && full_q[bus.slot_sel]) lock_fire = 1'b1;
          else                                 err_d     = 1'b1;
        end else if (bus.rd_req) begin
          if (slot_ok) begin
            rd_fire = 1'b1;
            rd_ok   = full_q[bus.slot_sel] && !(locked_q[bus.slot_sel] && bus.debug_mode);
            err_d   = !rd_ok;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ZERO: begin
        err_d = any_req;
        if (zcnt_q == WORD_W'(KEY_WORDS - 1)) begin
          zero_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int w = 0; w < KEY_WORDS; w++) mem_q[s][w] <= '0;
        ptr_q[s] <= '0;
      end
      full_q     <= '0;
      locked_q   <= '0;
      zslot_q    <= '0;
      zcnt_q     <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= err_d;
      rd_valid_q <= rd_fire;
      // Key material only appears on data_out for the single rd_valid cycle.
      data_out_q <= (rd_fire && rd_ok) ? mem_q[bus.slot_sel][bus.rd_word] : '0;
      if (wr_fire) begin
        mem_q[bus.slot_sel][ptr_q[bus.slot_sel]] <= bus.data_in;
        if (ptr_q[bus.slot_sel] == WORD_W'(KEY_WORDS - 1)) full_q[bus.slot_sel] <= 1'b1;
        else ptr_q[bus.slot_sel] <= ptr_q[bus.slot_sel] + WORD_W'(1);
      end
      if (lock_fire) locked_q[bus.slot_sel] <= 1'b1;
      if (zero_start) begin
        zslot_q <= bus.slot_sel;
        zcnt_q  <= '0;
      end
      if (state_q == ZERO) begin
        mem_q[zslot_q][zcnt_q] <= '0;
        zcnt_q                 <= zcnt_q + WORD_W'(1);
        if (zero_done) begin
          ptr_q[zslot_q]    <= '0;
          full_q[zslot_q]   <= 1'b0;
          locked_q[zslot_q] <= 1'b0;
        end
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q == ZERO);
  assign bus.slot_full   = full_q;
  assign bus.slot_locked = locked_q;

endmodule

// File: doc/crypto_key_vault.md
Name: crypto_key_vault

Overview:
Parametrised multi-slot successor to the single-register key store. Holds NUM_SLOTS keys of KEY_WORDS words each, DATA_W bits per word. Adds per-slot word-sequential loading, write-once locking, timed zeroization, debug-mode read masking and a registered read handshake. Sits between the key-provisioning bus and the cipher core's key-fetch port.

Parameters:
DATA_W, 16, bits per key word
NUM_SLOTS, 4, number of key slots (>=2)
KEY_WORDS, 8, words per key (>=2)
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived)
WORD_W, $clog2(KEY_WORDS), word index width (derived)

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  reset, asynchronous, active-low
slot_sel  in  SLOT_W  target slot for any command
write_en  in  1  write data_in as next word of slot_sel
data_in  in  DATA_W  key word to load
lock_req  in  1  lock slot_sel
zeroize_req  in  1  erase slot_sel
rd_req  in  1  read word rd_word of slot_sel
rd_word  in  WORD_W  word index for read
debug_mode  in  1  high = debug access active; masks locked keys
data_out  out  DATA_W  read data, valid only with rd_valid
rd_valid  out  1  one-cycle read strobe
busy  out  1  high while zeroizing
err  out  1  one-cycle pulse on rejected command
slot_full  out  NUM_SLOTS  bit i = slot i holds KEY_WORDS words
slot_locked  out  NUM_SLOTS  bit i = slot i locked

Behaviour:
- Reset (resetn=0, async): all storage words, write pointers, slot_full, slot_locked cleared to 0; data_out=0, rd_valid=0, err=0, busy=0; FSM -> IDLE. Applies immediately, including mid-zeroize.
- FSM: IDLE, ZERO. ZERO entered only from IDLE on accepted zeroize_req.
- Command priority in IDLE, one per cycle: zeroize_req > write_en > lock_req > rd_req. Lower-priority requests in the same cycle are dropped silently (no err).
- Write: slot unlocked and not full -> store data_in at slot's write pointer, pointer +1; on reaching KEY_WORDS, slot_full set next cycle and pointer holds. Write to locked or full slot -> no change, err pulse.
- Lock: slot full -> slot_locked bit set next cycle; sticky until zeroize or reset. Slot not full -> err, no change. Lock on already-locked slot -> no effect, no err.
- Read: 1-cycle latency; cycle after rd_req, rd_valid=1 and data_out=word. data_out forced to 0 with err pulse (rd_valid still 1) if slot not full, or slot locked and debug_mode=1. Locked slot with debug_mode=0 reads normally.
- data_out returns to 0 the cycle after every rd_valid pulse; never holds key material when idle.
- Zeroize: allowed on any slot incl. locked. ZERO lasts exactly KEY_WORDS cycles, word counter 0..KEY_WORDS-1 writing 0 per cycle; busy=1 for all those cycles. On final cycle: write pointer, slot_full, slot_locked of that slot cleared; FSM -> IDLE, busy=0 next cycle.
- During ZERO: write_en, lock_req, rd_req, zeroize_req ignored; each cycle any is asserted -> err pulse.
- err: registered, asserted the cycle after the offending request, one cycle per offence.
- Slot index >= NUM_SLOTS (non-power-of-2): command rejected with err.

Test Plan:
- Reset then read slot 0 word 0 -> rd_valid=1, data_out=0, err=1; slot_full=0, slot_locked=0.
- Write 0x1111..0x8888 to slot 2, read word 5 -> data_out=0x6666 one cycle after rd_req; slot_full[2]=1; ninth write -> err=1, contents unchanged.
- Lock slot 2, write 0xDEAD -> err=1; read with debug_mode=1 -> data_out=0, err=1; debug_mode=0 -> 0x6666.
- Zeroize locked slot 2 -> busy high exactly 8 cycles; rd_req at cycle 3 -> err, no rd_valid; afterwards slot_full[2]=0, slot_locked[2]=0, read -> 0 with err.
- Same cycle write_en+rd_req on slot 1 -> only write accepted, no rd_valid, no err; zeroize_req+write_en -> zeroize wins.
- Drop resetn mid-zeroize (cycle 4) of full slot 0 with slot 1 full -> all outputs 0 immediately, both slots empty after release.
